// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, column synchronizer, press/release debounce
// and a 4-entry first-word-fall-through key FIFO with a level interrupt.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_pop,
  output logic [2:0] fifo_count,
  output logic       overflow,
  output logic       irq,
  output logic [1:0] dbg_state
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [7:0]    CNT_LAST   = 8'(DEB_COUNT - 1);

  localparam logic [1:0] ST_SCAN      = 2'd0;
  localparam logic [1:0] ST_PRESS_DEB = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_REL_DEB   = 2'd3;

  logic [3:0]    col_m, col_s;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    state;
  logic [3:0]    lat_col, lat_code;
  logic [7:0]    deb_cnt, rel_cnt;
  logic          sample, col_onehot, push_req;

  logic [3:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       pop_ok, push_ok;

  function automatic logic [3:0] key_lookup(input logic [3:0] row, input logic [3:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      8'b1000_1000: code = 4'd1;
      8'b1000_0100: code = 4'd2;
      8'b1000_0010: code = 4'd3;
      8'b1000_0001: code = 4'd10;
      8'b0100_1000: code = 4'd4;
      8'b0100_0100: code = 4'd5;
      8'b0100_0010: code = 4'd6;
      8'b0100_0001: code = 4'd11;
      8'b0010_1000: code = 4'd7;
      8'b0010_0100: code = 4'd8;
      8'b0010_0010: code = 4'd9;
      8'b0010_0001: code = 4'd12;
      8'b0001_1000: code = 4'd14;
      8'b0001_0100: code = 4'd0;
      8'b0001_0010: code = 4'd15;
      8'b0001_0001: code = 4'd13;
      default:      code = 4'd0;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_m <= 4'd0;
      col_s <= 4'd0;
    end else begin
      col_m <= columnas;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       dwell_cnt <= '0;
    else if (sample) dwell_cnt <= '0;
    else             dwell_cnt <= dwell_cnt + 1'b1;
  end

  assign sample     = (dwell_cnt == DWELL_LAST);
  assign col_onehot = $onehot(col_s);
  // The DEB_COUNT-th matching sample writes the FIFO on the same edge it is seen.
  assign push_req   = sample && (state == ST_PRESS_DEB) && (col_s == lat_col) &&
                      (deb_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_SCAN;
      filas    <= 4'b1000;
      lat_col  <= 4'd0;
      lat_code <= 4'd0;
      deb_cnt  <= 8'd0;
      rel_cnt  <= 8'd0;
    end else if (sample) begin
      case (state)
        ST_SCAN: begin
          if (col_onehot) begin
            lat_col  <= col_s;
            lat_code <= key_lookup(filas, col_s);
            deb_cnt  <= 8'd1;
            state    <= ST_PRESS_DEB;
          end else begin
            filas <= {filas[0], filas[3:1]};
          end
        end
        ST_PRESS_DEB: begin
          if (col_s == lat_col) begin
            deb_cnt <= deb_cnt + 8'd1;
            if (deb_cnt == CNT_LAST) state <= ST_HELD;
          end else begin
            state <= ST_SCAN;
            filas <= {filas[0], filas[3:1]};
          end
        end
        ST_HELD: begin
          if (col_s == 4'd0) begin
            rel_cnt <= 8'd1;
            state   <= ST_REL_DEB;
          end
        end
        ST_REL_DEB: begin
          if (col_s != 4'd0) begin
            state <= ST_HELD;
          end else if (rel_cnt == CNT_LAST) begin
            state <= ST_SCAN;
            filas <= {filas[0], filas[3:1]};
          end else begin
            rel_cnt <= rel_cnt + 8'd1;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

  // key_valid/key_pop: key_code is the head whenever key_valid=1; a pop is taken on
  // any edge with key_pop=1 and key_valid=1, otherwise key_pop is ignored.
  assign pop_ok  = key_pop && (count != 3'd0);
  assign push_ok = push_req && ((count != 3'd4) || pop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= lat_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (pop_ok)                   overflow <= 1'b0;
      else if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  assign key_code   = mem[rd_ptr];
  assign key_valid  = (count != 3'd0);
  assign irq        = key_valid;
  assign fifo_count = count;
  assign dbg_state  = state;

endmodule
